// File: rtl/sqrt_pkg.sv
// Shared widths, FSM state encoding and operand helpers for the square-root sequencer.
// The SQRT_REM_EN build reuses the same encoding and adds the REM state.
package sqrt_pkg;

    localparam int XW = 64;
    localparam int RW = 32;
    localparam int NW = 6;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_STOP = 3'd3;
    localparam logic [2:0] S_CAPT = 3'd4;
    localparam logic [2:0] S_REM  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_LOAD = S_LOAD,
        ST_RUN  = S_RUN,
        ST_STOP = S_STOP,
        ST_CAPT = S_CAPT,
        ST_REM  = S_REM,
        ST_DONE = S_DONE
    } state_e;

    // The datapath works in bit pairs; 63 cannot round up within NW bits.
    function automatic logic [NW-1:0] norm_nbits(input logic [NW-1:0] n);
        if (n == {NW{1'b1}}) begin
            return n - NW'(1);
        end else if (n[0]) begin
            return n + NW'(1);
        end
        return n;
    endfunction

    function automatic logic [XW-1:0] mask_x(input logic [XW-1:0] x, input logic [NW-1:0] n);
        return x & ((XW'(1) << n) - XW'(1));
    endfunction

endpackage

// File: rtl/sqrt_seq_ctrl_if.sv
// Operand and result valid/ready channels of the square-root sequencer.
// out_rem exists only when SQRT_REM_EN is defined.
interface sqrt_seq_ctrl_if;
    import sqrt_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] in_nbits;
    logic [XW-1:0] in_x;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_sqrt;
`ifdef SQRT_REM_EN
    logic [RW:0]   out_rem;

    modport master (output in_valid, in_nbits, in_x, out_ready,
                    input  in_ready, out_valid, out_sqrt, out_rem);
    modport slave  (input  in_valid, in_nbits, in_x, out_ready,
                    output in_ready, out_valid, out_sqrt, out_rem);
`else
    modport master (output in_valid, in_nbits, in_x, out_ready,
                    input  in_ready, out_valid, out_sqrt);
    modport slave  (input  in_valid, in_nbits, in_x, out_ready,
                    output in_ready, out_valid, out_sqrt);
`endif

endinterface

// File: rtl/sqrt_iter_cnt.sv
// Loadable down-counter tracking the datapath iterations; last_o flags the final one.
// Latency: load and decrement take effect on the next clock edge.
// Backpressure: none, the sequencer FSM decides when to load and decrement.
module sqrt_iter_cnt
    import sqrt_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          dec_i,
    input  logic [NW-2:0] load_val_i,
    output logic          last_o
);

    logic [NW-2:0] cnt_q;
    logic [NW-2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - (NW-1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == (NW-1)'(1));

endmodule

// File: rtl/sqrt_seq_ctrl.sv
// Sequencer for the bit-serial square-root datapath; SQRT_REM_EN adds a remainder stage.
// Latency: out_valid K+3 cycles after accept (K+4 with SQRT_REM_EN), 1 cycle for nbits==0.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no buffering.
module sqrt_seq_ctrl
    import sqrt_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    sqrt_seq_ctrl_if.slave bus,
    output logic           dp_start_o,
    output logic           dp_stop_o,
    output logic [NW-1:0]  dp_nbits_o,
    output logic [XW-1:0]  dp_x_o,
    input  logic [RW-1:0]  dp_sqrt_i,
    output logic           busy_o
);

    state_e        state_q;
    logic          dp_start_q;
    logic          dp_stop_q;
    logic          out_valid_q;
    logic          zero_q;
    logic [NW-1:0] dp_nbits_q;
    logic [XW-1:0] dp_x_q;
    logic [RW-1:0] out_sqrt_q;
    logic          cnt_last;

`ifdef SQRT_REM_EN
    logic [RW:0]   out_rem_q;
    logic [XW-1:0] root_sq;

    assign root_sq = XW'(out_sqrt_q) * XW'(out_sqrt_q);
`endif

    // dp_nbits_q is even after normalisation, so its upper bits are the pair count K.
    sqrt_iter_cnt u_iter_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (state_q == ST_LOAD),
        .dec_i      (state_q == ST_RUN),
        .load_val_i (dp_nbits_q[NW-1:1]),
        .last_o     (cnt_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            dp_start_q  <= 1'b0;
            dp_stop_q   <= 1'b0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            dp_nbits_q  <= '0;
            dp_x_q      <= '0;
            out_sqrt_q  <= '0;
`ifdef SQRT_REM_EN
            out_rem_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        dp_x_q     <= mask_x(bus.in_x, bus.in_nbits);
                        dp_nbits_q <= norm_nbits(bus.in_nbits);
                        // A zero-width operand has root 0; the datapath is never started.
                        if (bus.in_nbits == '0) begin
                            zero_q  <= 1'b1;
                            state_q <= ST_CAPT;
                        end else begin
                            zero_q     <= 1'b0;
                            dp_start_q <= 1'b1;
                            state_q    <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    dp_start_q <= 1'b0;
                    state_q    <= ST_RUN;
                end
                ST_RUN: begin
                    if (cnt_last) begin
                        dp_stop_q <= 1'b1;
                        state_q   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    dp_stop_q <= 1'b0;
                    state_q   <= ST_CAPT;
                end
                ST_CAPT: begin
                    out_sqrt_q <= zero_q ? '0 : dp_sqrt_i;
`ifdef SQRT_REM_EN
                    if (zero_q) begin
                        out_rem_q   <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        state_q     <= ST_REM;
                    end
`else
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
`endif
                end
`ifdef SQRT_REM_EN
                ST_REM: begin
                    // x - s*s never exceeds 2s, so RW+1 bits always hold it.
                    out_rem_q   <= (RW+1)'(dp_x_q - root_sq);
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sqrt  = out_sqrt_q;
`ifdef SQRT_REM_EN
    assign bus.out_rem   = out_rem_q;
`endif
    assign dp_start_o    = dp_start_q;
    assign dp_stop_o     = dp_stop_q;
    assign dp_nbits_o    = dp_nbits_q;
    assign dp_x_o        = dp_x_q;

endmodule
